image_parallel_processing_mem_streamer: RTL and testbench
=========================================================

IMAGE_PARALLEL_PROCESSING_MEM_STREAMER -- requirements
Module: image_parallel_processing_mem_streamer

Interface
REQ-001 Parameter: ADDR_W, default 17, word-address width of the on-chip image memory.
REQ-002 Parameter: MEM_WORDS, default 120000, number of valid 32-bit words in the image memory.
REQ-003 Parameter: FIFO_DEPTH, default 4, output buffer entries (power of two, >=2).
REQ-004 Port: clk  in  1  single clock for all logic.
REQ-005 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port: start  in  1  one-cycle pulse to launch a transfer.
REQ-007 Port: base_addr  in  ADDR_W  first word address, sampled on accepted start.
REQ-008 Port: word_count  in  ADDR_W  number of words to stream, sampled on accepted start.
REQ-009 Port: busy  out  1  high from accepted start until done.
REQ-010 Port: done  out  1  one-cycle pulse at transfer completion.
REQ-011 Port: error  out  1  one-cycle pulse when start is rejected for range.
REQ-012 Port: mem_address  out  ADDR_W  read address to memory.
REQ-013 Port: mem_chipselect  out  1  read strobe; memory write held 0.
REQ-014 Port: mem_byteenable  out  4  constant 4'hF.
REQ-015 Port: mem_clken  out  1  constant 1.
REQ-016 Port: mem_readdata  in  32  memory data, valid exactly 1 cycle after chipselect.
REQ-017 Port: src_data  out  32  Avalon-ST pixel word.
REQ-018 Port: src_valid  out  1  src_data valid.
REQ-019 Port: src_ready  in  1  sink accepts when src_valid & src_ready.
REQ-020 Port: src_startofpacket  out  1  high with first word of transfer.
REQ-021 Port: src_endofpacket  out  1  high with last word of transfer.

Function
REQ-022 FSM states IDLE, RUN, DRAIN; IDLE after reset.
REQ-023 IDLE + start: if word_count==0 -> done pulse next cycle, stay IDLE, no reads; if base_addr+word_count > MEM_WORDS (computed ADDR_W+1 bits) -> error pulse next cycle, stay IDLE; else latch base/count, busy=1, go RUN.
REQ-024 start while busy is ignored; latched base/count unaffected.
REQ-025 RUN: issue one read per cycle (mem_chipselect=1, mem_address=base+issued) while issued<count and fifo_used+inflight < FIFO_DEPTH.
REQ-026 inflight is 1 in the cycle after a read issue, else 0; mem_readdata is written to the FIFO in that cycle unconditionally (space pre-reserved).
REQ-027 RUN -> DRAIN when the last read is issued; mem_chipselect low in DRAIN and IDLE.
REQ-028 FIFO: first-word-fall-through; src_valid = FIFO non-empty; pop on src_valid & src_ready; simultaneous push and pop keeps occupancy unchanged.
REQ-029 src_data/valid/sop/eop held stable while src_valid & ~src_ready.
REQ-030 src_startofpacket marks word index 0, src_endofpacket marks index count-1; both high for count==1.
REQ-031 DRAIN -> IDLE when the eop word is accepted; done pulses that same cycle as the registered output of the next cycle; busy drops with done.
REQ-032 Throughput: with src_ready constantly high, one word per cycle sustained; first src_valid 2 cycles after accepted start.
REQ-033 Counters (issued, popped) ADDR_W bits; no address wrap possible due to REQ-023 range check.

Reset
REQ-034 reset_n low asynchronously: state IDLE, FIFO empty, counters 0, busy/done/error/mem_chipselect/src_valid/sop/eop = 0, mem_address = 0, src_data = 0.
REQ-035 Reset mid-transfer discards in-flight and buffered data; no done pulse; next start behaves as from power-up.

Verification
REQ-036 base=0, count=8, src_ready=1 -> words mem[0..7] in order, 8 consecutive cycles, sop on word 0, eop on word 7, done one cycle after eop accept.
REQ-037 base=100, count=20, src_ready toggled random 50% -> all 20 words in order, none lost/duplicated, fifo never overflows, chipselect stalls when 4 reserved.
REQ-038 count=0 -> done pulse 1 cycle after start, no chipselect, no src_valid; base=119990, count=11 -> error pulse, busy stays 0.
REQ-039 count=1, base=119999 -> single word with sop=eop=1, then done.
REQ-040 reset_n low during RUN after 3 words accepted -> all outputs 0 immediately; subsequent start base=0, count=4 streams mem[0..3] correctly.
REQ-041 start pulsed again mid-transfer with different base -> ignored, original stream completes unchanged.

Source files
------------

// File: rtl/image_parallel_processing_mem_streamer_if.sv
// Bus bundle for the image streamer: memory read port plus the Avalon-ST pixel source.
// The master side is the streamer; the slave side is the memory and the downstream sink.
interface image_parallel_processing_mem_streamer_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [31:0]       mem_readdata;
    logic [31:0]       src_data;
    logic              src_valid;
    logic              src_ready;
    logic              src_startofpacket;
    logic              src_endofpacket;

    modport master (
        output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        input  mem_readdata,
        output src_data, src_valid, src_startofpacket, src_endofpacket,
        input  src_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        output mem_readdata,
        input  src_data, src_valid, src_startofpacket, src_endofpacket,
        output src_ready
    );
endinterface

// File: rtl/image_parallel_processing_mem_streamer.sv
// Streams a range of words from the image memory into an Avalon-ST packet.
// state | meaning
// IDLE  | waiting for start; range checked on start
// RUN   | issuing reads while FIFO space (including the read in flight) allows
// DRAIN | all reads issued; waiting for the eop word to be accepted
module image_parallel_processing_mem_streamer #(
    parameter int ADDR_W     = 17,
    parameter int MEM_WORDS  = 120000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    image_parallel_processing_mem_streamer_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]  DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W + 1)'(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, count_q, issued_q, popped_q;
    logic              inflight_q;
    logic              done_q, done_d, error_q, error_d, launch;
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  used_q;
    logic [CNT_W:0]    reserved;
    logic [ADDR_W:0]   range_end;
    logic              issue, pop, fifo_valid, last_word;

    assign fifo_valid = (used_q != '0);
    assign pop        = fifo_valid & bus.src_ready;
    assign last_word  = fifo_valid && (popped_q == count_q - ADDR_W'(1));
    // The read issued last cycle lands next edge, so it must already count against space.
    assign reserved   = {1'b0, used_q} + {{CNT_W{1'b0}}, inflight_q};
    assign issue      = (state_q == RUN) && (issued_q < count_q) && (reserved < DEPTH_L);
    assign range_end  = {1'b0, base_addr} + {1'b0, word_count};

    assign bus.mem_chipselect    = issue;
    assign bus.mem_address       = issue ? base_q + issued_q : '0;
    assign bus.mem_write         = 1'b0;
    assign bus.mem_byteenable    = 4'hF;
    assign bus.mem_clken         = 1'b1;
    assign bus.src_valid         = fifo_valid;
    assign bus.src_data          = fifo_valid ? fifo_mem[rd_ptr] : '0;
    assign bus.src_startofpacket = fifo_valid && (popped_q == '0);
    assign bus.src_endofpacket   = last_word;

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign error = error_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        done_d = 1'b1;
                    end else if (range_end > MEM_LIM) begin
                        error_d = 1'b1;
                    end else begin
                        launch  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (issue && (issued_q == count_q - ADDR_W'(1))) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && last_word) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q     <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (launch) begin
                base_q   <= base_addr;
                count_q  <= word_count;
                issued_q <= '0;
                popped_q <= '0;
            end else begin
                if (issue) issued_q <= issued_q + ADDR_W'(1);
                if (pop)   popped_q <= popped_q + ADDR_W'(1);
            end
        end
    end

    // Read data is pushed unconditionally one cycle after its read was issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            used_q <= '0;
        end else begin
            if (inflight_q) begin
                fifo_mem[wr_ptr] <= bus.mem_readdata;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            used_q <= used_q + CNT_W'(inflight_q) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_image_parallel_processing_mem_streamer.sv
// Directed bench for the image memory streamer with a memory model and a scoreboard
// of expected stream words filled when a transfer is launched.
module tb_image_parallel_processing_mem_streamer;
    localparam int ADDR_W     = 17;
    localparam int MEM_WORDS  = 120000;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] word_count = '0;
    logic              busy, done, error;

    image_parallel_processing_mem_streamer_if #(.ADDR_W(ADDR_W)) bus ();

    image_parallel_processing_mem_streamer #(
        .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .error(error), .bus(bus)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    beat_t sbq[$];
    int    cs_total = 0;
    int    acc_total = 0;
    bit    stall_q = 1'b0;
    beat_t stall_beat;

    function automatic logic [31:0] pat(input logic [ADDR_W-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory: registered read, garbage when not selected so stray pushes show up.
    always @(posedge clk) begin
        if (bus.mem_chipselect) bus.mem_readdata <= pat(bus.mem_address);
        else                    bus.mem_readdata <= 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("cs_only_when_busy", bus.mem_chipselect & ~busy, 1'b0);
            if (bus.mem_chipselect) begin
                chk("fifo_reservation", 64'((cs_total + 1 - acc_total) <= FIFO_DEPTH), 1);
                cs_total++;
            end
            if (stall_q) begin
                chk("stall_valid", bus.src_valid, 1'b1);
                chk("stall_beat", {bus.src_data, bus.src_startofpacket, bus.src_endofpacket},
                    stall_beat);
            end
            if (bus.src_valid && bus.src_ready) begin
                chk("sb_nonempty", 64'(sbq.size() > 0), 1);
                if (sbq.size() > 0) begin
                    beat_t e;
                    e = sbq.pop_front();
                    chk("beat_data", bus.src_data, e.data);
                    chk("beat_sop", bus.src_startofpacket, e.sop);
                    chk("beat_eop", bus.src_endofpacket, e.eop);
                end
                acc_total++;
            end
            stall_q    = bus.src_valid && !bus.src_ready;
            stall_beat = {bus.src_data, bus.src_startofpacket, bus.src_endofpacket};
        end else begin
            stall_q = 1'b0;
        end
    end

    // Drives a one-cycle start; returns one time unit after the sampling edge.
    task automatic do_start(input int b, input int n, input bit expect_stream);
        @(posedge clk); #1;
        if (expect_stream) begin
            cs_total  = 0;
            acc_total = 0;
            for (int i = 0; i < n; i++)
                sbq.push_back({pat(ADDR_W'(b + i)), i == 0, i == n - 1});
        end
        start = 1'b1; base_addr = ADDR_W'(b); word_count = ADDR_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk(tag, seen, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.src_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_cs", bus.mem_chipselect, 0);
        chk("rst_addr", bus.mem_address, 0);
        chk("rst_valid", bus.src_valid, 0);
        chk("rst_sop_eop", {bus.src_startofpacket, bus.src_endofpacket}, 0);
        chk("rst_data", bus.src_data, 0);
        chk("mem_write", bus.mem_write, 0);
        chk("byteenable", bus.mem_byteenable, 4'hF);
        chk("clken", bus.mem_clken, 1);
        reset_n = 1'b1;

        // base 0, 8 words, sink always ready: exact latency and back-to-back beats.
        do_start(0, 8, 1);
        chk("t1_busy", busy, 1);
        chk("t1_cs", bus.mem_chipselect, 1);
        chk("t1_addr", bus.mem_address, 0);
        chk("t1_valid_e0", bus.src_valid, 0);
        @(posedge clk); #1;
        chk("t1_valid_e1", bus.src_valid, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("t1_valid_run", bus.src_valid, 1);
        end
        @(posedge clk); #1;
        chk("t1_done", done, 1);
        chk("t1_busy_drop", busy, 0);
        @(posedge clk); #1;
        chk("t1_done_pulse", done, 0);
        chk("t1_sb_empty", sbq.size(), 0);

        // base 100, 20 words, sink stalled then random: read stalls at 4 reserved.
        bus.src_ready = 1'b0;
        do_start(100, 20, 1);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 600 && !seen; i++) begin
                @(posedge clk); #1;
                if (i == 7) chk("t2_reads_when_full", cs_total, 4);
                bus.src_ready = (i < 7) ? 1'b0 : 1'(($urandom_range(0, 1)));
                if (done) seen = 1'b1;
            end
            chk("t2_done", seen, 1);
        end
        bus.src_ready = 1'b1;
        chk("t2_sb_empty", sbq.size(), 0);
        chk("t2_accepted", acc_total, 20);

        // Zero-length request completes immediately without touching memory.
        do_start(7, 0, 0);
        chk("t3_done", done, 1);
        chk("t3_busy", busy, 0);
        chk("t3_cs", bus.mem_chipselect, 0);
        @(posedge clk); #1;
        chk("t3_done_pulse", done, 0);
        chk("t3_valid", bus.src_valid, 0);

        // One word past the end of memory is rejected.
        do_start(119990, 11, 0);
        chk("t4_error", error, 1);
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        @(posedge clk); #1;
        chk("t4_error_pulse", error, 0);
        chk("t4_busy_after", busy, 0);

        // Last word of memory, single-beat packet.
        do_start(119999, 1, 1);
        chk("t5_error", error, 0);
        wait_done("t5_done", 20);
        chk("t5_sb_empty", sbq.size(), 0);

        // Reset during RUN after three accepted words.
        do_start(50, 10, 1);
        repeat (4) @(posedge clk);
        @(negedge clk); #2;
        chk("t6_accepted_before_rst", acc_total, 3);
        reset_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_cs", bus.mem_chipselect, 0);
        chk("t6_addr", bus.mem_address, 0);
        chk("t6_valid", bus.src_valid, 0);
        chk("t6_sop_eop", {bus.src_startofpacket, bus.src_endofpacket}, 0);
        chk("t6_data", bus.src_data, 0);
        chk("t6_done", done, 0);
        sbq.delete();
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_no_done", done, 0);
        do_start(0, 4, 1);
        wait_done("t6_restart_done", 30);
        chk("t6_sb_empty", sbq.size(), 0);

        // Second start mid-transfer is ignored.
        do_start(200, 12, 1);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; base_addr = ADDR_W'(5); word_count = ADDR_W'(3);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t7_done", 40);
        chk("t7_sb_empty", sbq.size(), 0);
        chk("t7_accepted", acc_total, 12);
        repeat (6) @(posedge clk);
        #1;
        chk("t7_idle_busy", busy, 0);
        chk("t7_idle_valid", bus.src_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
